vanilla_exe_bubble_profiler: RTL and testbench
==============================================

Name: vanilla_exe_bubble_profiler

Overview:
- Consumer of the EXE-stage bubble classification stream: takes the per-cycle bubble type and PC and builds a per-type histogram of bubble cycles.
- Per type, keeps a saturating counter and the PC of the last bubble of that type.
- Host/testbench reads entries over a valid/ready request, valid/yumi response interface. A sequenced clear sweeps all entries.
- Sits in the testbench beside each vanilla core's bubble classifier.

Parameters:
- pc_width_p, 32: width of the bubble PC.
- num_types_p, 32: number of histogram entries. Index num_types_p-1 is the catch-all for out-of-range types.
- counter_width_p, 32: width of each bubble counter and of the cycle counter.
- no_bubble_type_p, 24: type code meaning "no bubble"; never counted.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- en_i  in  1  profiling enable
- stall_all_i  in  1  pipeline-wide stall; EXE contents held this cycle
- exe_bubble_type_i  in  32  bubble type code
- exe_bubble_pc_i  in  pc_width_p  PC attributed to the bubble
- clear_i  in  1  single-cycle clear request
- busy_o  out  1  clear sweep in progress
- rd_v_i  in  1  read request valid
- rd_addr_i  in  $clog2(num_types_p)  entry index to read
- rd_ready_o  out  1  read request accepted
- rd_v_o  out  1  read response valid
- rd_count_o  out  counter_width_p  counter value of the requested entry
- rd_last_pc_o  out  pc_width_p  last PC recorded for the requested entry
- rd_yumi_i  in  1  response consumed
- cycle_count_o  out  counter_width_p  number of counted (advancing) cycles

Behaviour:
- Reset (asynchronous, reset_n_i=0): all counters and PCs are 0; state is IDLE; rd_v_o=0, busy_o=0, cycle_count_o=0, rd_count_o=0, rd_last_pc_o=0; any pending clear is dropped. Reset mid-sweep or mid-response aborts immediately.
- Advancing cycle: en_i & ~stall_all_i & ~busy_o.
  - cycle_count_o increments by 1 and saturates at all-ones.
- Event: an advancing cycle with exe_bubble_type_i != no_bubble_type_p.
  - Index = type if type < num_types_p, else num_types_p-1.
  - count[idx] increments by 1 and saturates at all-ones; last_pc[idx] <= exe_bubble_pc_i.
  - During stall_all_i nothing is counted, so a held bubble counts once per advance.
- States: IDLE, RESP, CLEAR.
- IDLE:
  - rd_ready_o = ~clear_i.
  - clear_i=1 -> CLEAR. Clear wins over a simultaneous rd_v_i; the read is not accepted.
  - rd_v_i & rd_ready_o -> capture count[rd_addr_i] and last_pc[rd_addr_i] as registered at that edge. The capture excludes any same-cycle increment. Go to RESP; rd_v_o=1 next cycle.
- RESP:
  - rd_ready_o=0; rd_v_o=1; rd_count_o and rd_last_pc_o stay stable until rd_yumi_i.
  - rd_yumi_i -> IDLE, rd_v_o=0 next cycle. rd_yumi_i is ignored when rd_v_o=0.
  - clear_i in RESP sets clear_pending. After yumi the next state is CLEAR instead of IDLE.
  - Counting continues in RESP.
- CLEAR:
  - busy_o=1, rd_ready_o=0. The sweep index i runs 0..num_types_p-1, one entry per cycle, zeroing count[i] and last_pc[i].
  - cycle_count_o is zeroed on the CLEAR entry edge.
  - No events are counted during CLEAR; they are dropped.
  - clear_i during CLEAR is ignored.
  - After index num_types_p-1: -> IDLE, busy_o=0, clear_pending=0.
  - Total latency from clear_i to busy_o=0 is num_types_p+1 cycles.
- rd_addr_i >= num_types_p (non-power-of-two case): the read returns count=0 and pc=0.
- Outputs are registered; there is no combinational path from rd_yumi_i to rd_v_o.

Test Plan:
- Reset, then 5 advancing cycles of type 3 at PC 0x100, 0x104, …, 0x110 -> read addr 3 returns count=5, last_pc=0x110; cycle_count_o=5.
- Type 7 held for 4 cycles with stall_all_i=1 for the middle 2 -> count[7]=2; type no_bubble_type_p for 10 cycles -> no entry changes, cycle_count_o +10.
- Type 40 once with num_types_p=32 -> count[31]=1; preload count[5]=0xFFFFFFFF, one more type-5 event -> stays 0xFFFFFFFF.
- Issue a read of addr 2 (count 9) while a type-2 event occurs the same cycle -> rd_count_o=9. Hold rd_yumi_i=0 for 3 cycles -> response stable; a later read -> 10.
- clear_i during RESP -> clear deferred until yumi. Then busy_o=1 for 32 cycles, all reads return 0, events during the sweep are not counted.
- clear_i and rd_v_i asserted together in IDLE -> read not accepted, CLEAR taken. Assert reset_n_i=0 asynchronously mid-sweep -> outputs go to 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/vanilla_exe_bubble_profiler.sv
// Per-type histogram of EXE-stage bubble cycles with last-PC capture, a registered
// valid/ready read port and a sequenced clear sweep.
module vanilla_exe_bubble_profiler #(
    parameter int unsigned pc_width_p       = 32,
    parameter int unsigned num_types_p      = 32,
    parameter int unsigned counter_width_p  = 32,
    parameter int unsigned no_bubble_type_p = 24
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           en_i,
    input  logic                           stall_all_i,
    input  logic [31:0]                    exe_bubble_type_i,
    input  logic [pc_width_p-1:0]          exe_bubble_pc_i,
    input  logic                           clear_i,
    output logic                           busy_o,
    input  logic                           rd_v_i,
    input  logic [$clog2(num_types_p)-1:0] rd_addr_i,
    output logic                           rd_ready_o,
    output logic                           rd_v_o,
    output logic [counter_width_p-1:0]     rd_count_o,
    output logic [pc_width_p-1:0]          rd_last_pc_o,
    input  logic                           rd_yumi_i,
    output logic [counter_width_p-1:0]     cycle_count_o
);

    localparam int unsigned IdxW = $clog2(num_types_p);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(num_types_p - 1);

    typedef enum logic [1:0] {StIdle, StResp, StClear} state_e;

    state_e                     state_q;
    logic [counter_width_p-1:0] count_q   [num_types_p];
    logic [pc_width_p-1:0]      last_pc_q [num_types_p];
    logic [counter_width_p-1:0] cycle_q;
    logic [counter_width_p-1:0] rd_count_q;
    logic [pc_width_p-1:0]      rd_last_pc_q;
    logic [IdxW-1:0]            clr_idx_q;
    logic                       clear_pending_q;

    logic                       advance;
    logic                       event_v;
    logic [IdxW-1:0]            ev_idx;
    logic                       rd_in_range;

    always_comb begin
        advance     = en_i & ~stall_all_i & (state_q != StClear);
        event_v     = advance & (exe_bubble_type_i != no_bubble_type_p);
        // Out-of-range type codes fold into the last entry.
        ev_idx      = (exe_bubble_type_i < num_types_p) ? exe_bubble_type_i[IdxW-1:0] : LastIdx;
        rd_in_range = 32'(rd_addr_i) < num_types_p;
    end

    assign busy_o        = (state_q == StClear);
    assign rd_v_o        = (state_q == StResp);
    assign rd_ready_o    = (state_q == StIdle) & ~clear_i;
    assign rd_count_o    = rd_count_q;
    assign rd_last_pc_o  = rd_last_pc_q;
    assign cycle_count_o = cycle_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= StIdle;
            cycle_q         <= '0;
            rd_count_q      <= '0;
            rd_last_pc_q    <= '0;
            clr_idx_q       <= '0;
            clear_pending_q <= 1'b0;
            for (int i = 0; i < int'(num_types_p); i++) begin
                count_q[i]   <= '0;
                last_pc_q[i] <= '0;
            end
        end else begin
            if (advance && (cycle_q != '1)) begin
                cycle_q <= cycle_q + counter_width_p'(1);
            end
            if (event_v) begin
                if (count_q[ev_idx] != '1) begin
                    count_q[ev_idx] <= count_q[ev_idx] + counter_width_p'(1);
                end
                last_pc_q[ev_idx] <= exe_bubble_pc_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        state_q   <= StClear;
                        clr_idx_q <= '0;
                        cycle_q   <= '0;
                    end else if (rd_v_i) begin
                        // Captures the pre-edge value; a same-cycle event is not visible.
                        rd_count_q   <= rd_in_range ? count_q[rd_addr_i] : '0;
                        rd_last_pc_q <= rd_in_range ? last_pc_q[rd_addr_i] : '0;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    if (clear_i) begin
                        clear_pending_q <= 1'b1;
                    end
                    if (rd_yumi_i) begin
                        if (clear_pending_q || clear_i) begin
                            state_q   <= StClear;
                            clr_idx_q <= '0;
                            cycle_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StClear: begin
                    count_q[clr_idx_q]   <= '0;
                    last_pc_q[clr_idx_q] <= '0;
                    if (clr_idx_q == LastIdx) begin
                        state_q         <= StIdle;
                        clear_pending_q <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + IdxW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vanilla_exe_bubble_profiler.sv
// Directed bench: a default-sized profiler plus a narrow (6 types, 4-bit counters) one for
// saturation, catch-all and out-of-range reads.
module tb_vanilla_exe_bubble_profiler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset_n;
    logic        en, stall, clear, rd_v, yumi;
    logic [31:0] btype, bpc;
    logic [4:0]  rd_addr;
    logic        busy, rd_ready, rd_vo;
    logic [31:0] rd_count, rd_pc, cycle;

    logic        en2, stall2, clear2, rd_v2, yumi2;
    logic [31:0] btype2, bpc2;
    logic [2:0]  rd_addr2;
    logic        busy2, rd_ready2, rd_vo2;
    logic [3:0]  rd_count2, cycle2;
    logic [31:0] rd_pc2;

    vanilla_exe_bubble_profiler dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en),
        .stall_all_i      (stall),
        .exe_bubble_type_i(btype),
        .exe_bubble_pc_i  (bpc),
        .clear_i          (clear),
        .busy_o           (busy),
        .rd_v_i           (rd_v),
        .rd_addr_i        (rd_addr),
        .rd_ready_o       (rd_ready),
        .rd_v_o           (rd_vo),
        .rd_count_o       (rd_count),
        .rd_last_pc_o     (rd_pc),
        .rd_yumi_i        (yumi),
        .cycle_count_o    (cycle)
    );

    vanilla_exe_bubble_profiler #(
        .num_types_p    (6),
        .counter_width_p(4)
    ) dut2 (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en2),
        .stall_all_i      (stall2),
        .exe_bubble_type_i(btype2),
        .exe_bubble_pc_i  (bpc2),
        .clear_i          (clear2),
        .busy_o           (busy2),
        .rd_v_i           (rd_v2),
        .rd_addr_i        (rd_addr2),
        .rd_ready_o       (rd_ready2),
        .rd_v_o           (rd_vo2),
        .rd_count_o       (rd_count2),
        .rd_last_pc_o     (rd_pc2),
        .rd_yumi_i        (yumi2),
        .cycle_count_o    (cycle2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input logic [4:0] a, output logic [31:0] c, output logic [31:0] p);
        int n;
        rd_v = 1'b1;
        rd_addr = a;
        step();
        rd_v = 1'b0;
        n = 0;
        while (!rd_vo && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (!rd_vo) begin
            errors++;
            $display("FAIL rd1_timeout: addr %0d got rd_v_o=%b after %0d cycles, need 1", a, rd_vo, n);
        end
        c = rd_count;
        p = rd_pc;
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] a, output logic [3:0] c, output logic [31:0] p);
        int n;
        rd_v2 = 1'b1;
        rd_addr2 = a;
        step();
        rd_v2 = 1'b0;
        n = 0;
        while (!rd_vo2 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (!rd_vo2) begin
            errors++;
            $display("FAIL rd2_timeout: addr %0d got rd_v_o=%b after %0d cycles, need 1", a, rd_vo2, n);
        end
        c = rd_count2;
        p = rd_pc2;
        yumi2 = 1'b1;
        step();
        yumi2 = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({rd_vo, busy} !== 2'b00 || cycle !== 32'd0 || rd_count !== 32'd0 || rd_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b busy=%b cyc=%0d cnt=%0d pc=%h, need all 0",
                     rd_vo, busy, cycle, rd_count, rd_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b need 1", rd_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] c, p;
        en = 1'b1;
        btype = 32'd3;
        for (int k = 0; k < 5; k++) begin
            bpc = 32'h100 + 32'(4 * k);
            step();
        end
        en = 1'b0;
        checks++;
        if (cycle !== 32'd5) begin
            errors++;
            $display("FAIL basic_cycle: got %0d need 5", cycle);
        end
        rd1(5'd3, c, p);
        checks++;
        if (c !== 32'd5 || p !== 32'h110) begin
            errors++;
            $display("FAIL basic_read3: got cnt=%0d pc=%h need cnt=5 pc=110", c, p);
        end
        rd1(5'd4, c, p);
        checks++;
        if (c !== 32'd0 || p !== 32'd0) begin
            errors++;
            $display("FAIL basic_read4: got cnt=%0d pc=%h need 0/0", c, p);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        checks++;
        if (rd_vo !== 1'b0 || rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_yumi: got v=%b ready=%b need v=0 ready=1", rd_vo, rd_ready);
        end
    endtask

    task automatic test_stall();
        logic [31:0] c, p;
        en = 1'b1;
        btype = 32'd7;
        bpc = 32'h200;
        stall = 1'b0; step();
        stall = 1'b1; step();
        step();
        stall = 1'b0; step();
        btype = 32'd24;
        bpc = 32'hdead;
        repeat (10) step();
        en = 1'b0;
        checks++;
        if (cycle !== 32'd17) begin
            errors++;
            $display("FAIL stall_cycle: got %0d need 17", cycle);
        end
        rd1(5'd7, c, p);
        checks++;
        if (c !== 32'd2 || p !== 32'h200) begin
            errors++;
            $display("FAIL stall_read7: got cnt=%0d pc=%h need cnt=2 pc=200", c, p);
        end
        rd1(5'd3, c, p);
        checks++;
        if (c !== 32'd5 || p !== 32'h110) begin
            errors++;
            $display("FAIL nobubble_read3: got cnt=%0d pc=%h need cnt=5 pc=110", c, p);
        end
        rd1(5'd24, c, p);
        checks++;
        if (c !== 32'd0) begin
            errors++;
            $display("FAIL nobubble_read24: got cnt=%0d need 0", c);
        end
    endtask

    task automatic test_catchall();
        logic [31:0] c, p;
        en = 1'b1;
        btype = 32'd40;
        bpc = 32'h300;
        step();
        en = 1'b0;
        rd1(5'd31, c, p);
        checks++;
        if (c !== 32'd1 || p !== 32'h300) begin
            errors++;
            $display("FAIL catchall_read31: got cnt=%0d pc=%h need cnt=1 pc=300", c, p);
        end
    endtask

    task automatic test_read_collision();
        logic [31:0] c, p;
        en = 1'b1;
        btype = 32'd2;
        bpc = 32'h400;
        repeat (9) step();
        bpc = 32'h480;
        rd_v = 1'b1;
        rd_addr = 5'd2;
        step();
        rd_v = 1'b0;
        en = 1'b0;
        checks++;
        if (rd_vo !== 1'b1 || rd_count !== 32'd9 || rd_pc !== 32'h400) begin
            errors++;
            $display("FAIL collide_capture: got v=%b cnt=%0d pc=%h need v=1 cnt=9 pc=400",
                     rd_vo, rd_count, rd_pc);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rd_vo !== 1'b1 || rd_ready !== 1'b0 || rd_count !== 32'd9 || rd_pc !== 32'h400) begin
                errors++;
                $display("FAIL resp_hold%0d: got v=%b rdy=%b cnt=%0d pc=%h need v=1 rdy=0 cnt=9 pc=400",
                         k, rd_vo, rd_ready, rd_count, rd_pc);
            end
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        checks++;
        if (rd_vo !== 1'b0) begin
            errors++;
            $display("FAIL resp_yumi: got v=%b need 0", rd_vo);
        end
        rd1(5'd2, c, p);
        checks++;
        if (c !== 32'd10 || p !== 32'h480 || cycle !== 32'd28) begin
            errors++;
            $display("FAIL collide_reread: got cnt=%0d pc=%h cyc=%0d need cnt=10 pc=480 cyc=28",
                     c, p, cycle);
        end
    endtask

    task automatic test_clear_deferred();
        logic [31:0] c, p;
        int n;
        rd_v = 1'b1;
        rd_addr = 5'd2;
        step();
        rd_v = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (rd_vo !== 1'b1 || busy !== 1'b0 || cycle !== 32'd28) begin
            errors++;
            $display("FAIL clear_deferred: got v=%b busy=%b cyc=%0d need v=1 busy=0 cyc=28",
                     rd_vo, busy, cycle);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        en = 1'b1;
        btype = 32'd2;
        bpc = 32'h999;
        checks++;
        if (busy !== 1'b1 || rd_vo !== 1'b0 || cycle !== 32'd0) begin
            errors++;
            $display("FAIL clear_entry: got busy=%b v=%b cyc=%0d need busy=1 v=0 cyc=0",
                     busy, rd_vo, cycle);
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        en = 1'b0;
        checks++;
        if (n !== 32 || cycle !== 32'd0) begin
            errors++;
            $display("FAIL clear_sweep: got busy_cycles=%0d cyc=%0d need 32 and 0", n, cycle);
        end
        for (int k = 0; k < 4; k++) begin
            logic [4:0] a;
            case (k)
                0: a = 5'd2;
                1: a = 5'd3;
                2: a = 5'd7;
                default: a = 5'd31;
            endcase
            rd1(a, c, p);
            checks++;
            if (c !== 32'd0 || p !== 32'd0) begin
                errors++;
                $display("FAIL cleared_read%0d: got cnt=%0d pc=%h need 0/0", a, c, p);
            end
        end
    endtask

    task automatic test_clear_vs_read_reset();
        logic [31:0] c, p;
        en = 1'b1;
        btype = 32'd9;
        bpc = 32'h500;
        step();
        en = 1'b0;
        rd1(5'd9, c, p);
        checks++;
        if (c !== 32'd1 || p !== 32'h500) begin
            errors++;
            $display("FAIL pre_clear_read9: got cnt=%0d pc=%h need cnt=1 pc=500", c, p);
        end
        clear = 1'b1;
        rd_v = 1'b1;
        rd_addr = 5'd9;
        #1;
        checks++;
        if (rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_read_ready: got %b need 0", rd_ready);
        end
        step();
        clear = 1'b0;
        rd_v = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_vo !== 1'b0 || cycle !== 32'd0) begin
            errors++;
            $display("FAIL clear_wins: got busy=%b v=%b cyc=%0d need busy=1 v=0 cyc=0",
                     busy, rd_vo, cycle);
        end
        repeat (10) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, rd_vo} !== 2'b00 || cycle !== 32'd0 || rd_count !== 32'd0 || rd_pc !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b v=%b cyc=%0d cnt=%0d pc=%h need all 0",
                     busy, rd_vo, cycle, rd_count, rd_pc);
        end
        #3;
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b rdy=%b need 0/1", busy, rd_ready);
        end
        rd1(5'd9, c, p);
        checks++;
        if (c !== 32'd0 || p !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_read9: got cnt=%0d pc=%h need 0/0", c, p);
        end
    endtask

    task automatic test_saturation();
        logic [3:0]  c;
        logic [31:0] p;
        en2 = 1'b1;
        btype2 = 32'd1;
        bpc2 = 32'h50;
        repeat (20) step();
        btype2 = 32'd40;
        bpc2 = 32'h60;
        step();
        en2 = 1'b0;
        checks++;
        if (cycle2 !== 4'hF) begin
            errors++;
            $display("FAIL sat_cycle: got %0d need 15", cycle2);
        end
        rd2(3'd1, c, p);
        checks++;
        if (c !== 4'hF || p !== 32'h50) begin
            errors++;
            $display("FAIL sat_read1: got cnt=%0d pc=%h need cnt=15 pc=50", c, p);
        end
        rd2(3'd5, c, p);
        checks++;
        if (c !== 4'd1 || p !== 32'h60) begin
            errors++;
            $display("FAIL sat_catchall5: got cnt=%0d pc=%h need cnt=1 pc=60", c, p);
        end
        rd2(3'd7, c, p);
        checks++;
        if (c !== 4'd0 || p !== 32'd0) begin
            errors++;
            $display("FAIL oob_read7: got cnt=%0d pc=%h need 0/0", c, p);
        end
        rd2(3'd6, c, p);
        checks++;
        if (c !== 4'd0 || p !== 32'd0) begin
            errors++;
            $display("FAIL oob_read6: got cnt=%0d pc=%h need 0/0", c, p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        {en, stall, clear, rd_v, yumi} = '0;
        btype = 32'd24;
        bpc = '0;
        rd_addr = '0;
        {en2, stall2, clear2, rd_v2, yumi2} = '0;
        btype2 = 32'd24;
        bpc2 = '0;
        rd_addr2 = '0;

        test_reset();
        test_basic();
        test_stall();
        test_catchall();
        test_read_collision();
        test_clear_deferred();
        test_clear_vs_read_reset();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
